// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor: WIDTH-bit diff = a - b - bin with the borrow chain cut into STAGE_W-bit pipelined slices.
// Optional macro PIPE_SUB_OVF_EN drives ovf with signed overflow; without it ovf is tied low.
module pipelined_subtractor #(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int STAGES = (STAGE_W > 0) ? WIDTH / STAGE_W : 1;
    localparam int LAST   = STAGES - 1;
    localparam int REM    = (STAGE_W > 0) ? WIDTH % STAGE_W : 1;

    if (WIDTH < 2 || STAGE_W < 1 || STAGES < 1 || REM != 0) begin : g_param_check
        $error("pipelined_subtractor: WIDTH must be >= 2 and a multiple of STAGE_W >= 1");
    end

    // Stage k holds operands shifted so its own slice sits in the low bits, the borrow into
    // that slice, and the already-finished lower diff slices packed at the top of dacc_q.
    logic               vld_q  [STAGES];
    logic [WIDTH-1:0]   a_q    [STAGES];
    logic [WIDTH-1:0]   b_q    [STAGES];
    logic               br_q   [STAGES];
    logic [WIDTH-1:0]   dacc_q [STAGES];
    logic [STAGE_W-1:0] ds     [STAGES];
    logic               bo     [STAGES];
    logic               adv;

    function automatic logic [WIDTH-1:0] push_slice(input logic [WIDTH-1:0]   acc,
                                                    input logic [STAGE_W-1:0] s);
        return (acc >> STAGE_W) | (WIDTH'(s) << (WIDTH - STAGE_W));
    endfunction

    assign out_valid = vld_q[LAST];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic borrow;

        always_comb begin
            borrow = br_q[k];
            ds[k]  = '0;
            for (int i = 0; i < STAGE_W; i++) begin
                ds[k][i] = a_q[k][i] ^ b_q[k][i] ^ borrow;
                borrow   = (~a_q[k][i] & b_q[k][i]) | (~(a_q[k][i] ^ b_q[k][i]) & borrow);
            end
            bo[k] = borrow;
        end

        if (k == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q[0]  <= 1'b0;
                    a_q[0]    <= '0;
                    b_q[0]    <= '0;
                    br_q[0]   <= 1'b0;
                    dacc_q[0] <= '0;
                end else if (adv) begin
                    vld_q[0] <= in_valid;
                    if (in_valid) begin
                        a_q[0]    <= a;
                        b_q[0]    <= b;
                        br_q[0]   <= bin;
                        dacc_q[0] <= '0;
                    end
                end
            end
        end else begin : g_body
            // Data only moves with a token so idle stages keep their last contents.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q[k]  <= 1'b0;
                    a_q[k]    <= '0;
                    b_q[k]    <= '0;
                    br_q[k]   <= 1'b0;
                    dacc_q[k] <= '0;
                end else if (adv) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        a_q[k]    <= a_q[k-1] >> STAGE_W;
                        b_q[k]    <= b_q[k-1] >> STAGE_W;
                        br_q[k]   <= bo[k-1];
                        dacc_q[k] <= push_slice(dacc_q[k-1], ds[k-1]);
                    end
                end
            end
        end
    end

    assign diff = push_slice(dacc_q[LAST], ds[LAST]);
    assign bout = bo[LAST];

`ifdef PIPE_SUB_OVF_EN
    // The final stage already holds the operand MSBs in the top bit of its slice.
    assign ovf = (a_q[LAST][STAGE_W-1] ^ b_q[LAST][STAGE_W-1])
               & (a_q[LAST][STAGE_W-1] ^ ds[LAST][STAGE_W-1]);
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
Parametrised WIDTH-bit subtractor computing diff = a - b - bin, with borrow-out. The borrow chain is split into STAGE_W-bit slices, and there is one register stage per slice, which gives one result per cycle at high clock rates. Valid/ready handshake on input and output lets it sit in the datapath between producer and consumer blocks. It replaces fixed 4-bit ripple subtraction for wide operands.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 2 and divisible by STAGE_W.
STAGE_W, 4, bits resolved per pipeline stage; STAGES = WIDTH/STAGE_W, must be >= 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands a, b, bin are valid this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in to bit 0
out_valid  output  1  diff/bout/ovf hold a valid result
out_ready  input  1  consumer accepts result this cycle
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow out of MSB (1 when unsigned a < b + bin)
ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valid bits 0, out_valid=0, diff=0, bout=0, ovf=0. in_ready=1 in the cycle after reset.
- Reset mid-operation: every in-flight result is discarded. No output fires after reset deasserts until new operands are accepted.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid/out_ready only, never from in_valid.
- When adv=0, all stage registers, including operand skew registers and partial results, hold. out_valid, diff, bout and ovf stay stable until the result is accepted.
- When adv=1, every stage shifts forward by one. A stage's valid bit loads the previous stage's valid bit; stage 0 loads (in_valid && in_ready).
- Stage k (k=0..STAGES-1) computes bits [k*STAGE_W +: STAGE_W] from its registered a/b slice and the borrow registered by stage k-1 (bin for k=0). It registers the slice difference and the slice borrow-out.
- Slice borrow per bit: bo = (~x & y) | (~(x ^ y) & bi); d = x ^ y ^ bi.
- Operand skew: the upper slices of a and b, and the completed lower diff slices, travel with the token so each result is assembled coherently.
- Latency: STAGES cycles from input transfer to out_valid, with no backpressure. Throughput: one result per cycle while out_ready=1.
- Ordering: results leave in acceptance order. No drops and no duplicates.
- Bubbles: cycles with in_valid=0 produce bubbles. Bubbles do not stall following tokens when the output is free.
- Ignored inputs: a, b and bin are don't-care when in_valid=0.
- Boundary cases: a=b, bin=0 -> diff=0, bout=0. a=0, b=2^WIDTH-1, bin=1 -> diff=0, bout=1.
- STAGE_W=WIDTH: single-stage case, latency 1.
- Elaboration: illegal parameter combinations trigger an elaboration-time error via a generate-time check.

Optional Feature:
- Macro: PIPE_SUB_OVF_EN.
- With the macro defined: ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]). It is computed in the final stage and is valid with out_valid.
- Without the macro: the ovf port remains and is tied to 0, and no MSB-tracking logic is synthesised.

Test Plan:
- WIDTH=16, STAGE_W=4, out_ready=1; a=0x1234, b=0x0235, bin=0 -> after 4 cycles out_valid=1, diff=0x0FFF, bout=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. Then a=0x0005, b=0x0004, bin=1 -> diff=0x0000, bout=0.
- With PIPE_SUB_OVF_EN: a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1. Without the macro, ovf=0 for both.
- Backpressure: stream 8 random operand pairs on consecutive cycles, out_ready=0 on cycles 5-7 -> in_ready low while the output is stalled, all 8 results are correct against a reference model, in order, with none lost, and diff stays stable during the stall.
- Reset mid-flight: accept 3 operands, assert rst for 1 cycle on cycle 2 -> out_valid=0, diff=0, bout=0 next cycle, and no stale result ever appears.
- Parameter sweep: (WIDTH,STAGE_W) = (8,8), (8,1), (32,4) with 1000 random vectors -> latency = WIDTH/STAGE_W, all results match a - b - bin mod 2^WIDTH and bout.
